// File: rtl/sync_pkg.sv
// Shared helpers for the Gray pointer synchronisers: code conversion, bit count and depth limits.
package sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  // Helpers work on a fixed wide vector; callers zero-extend and truncate to their pointer width.
  localparam int SYNC_MAX_W      = 32;

  function automatic logic [SYNC_MAX_W-1:0] gray2bin(input logic [SYNC_MAX_W-1:0] g);
    logic [SYNC_MAX_W-1:0] b;
    b[SYNC_MAX_W-1] = g[SYNC_MAX_W-1];
    for (int i = SYNC_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [SYNC_MAX_W-1:0] bin2gray(input logic [SYNC_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] popcount(input logic [SYNC_MAX_W-1:0] v);
    logic [31:0] c;
    c = 32'd0;
    for (int i = 0; i < SYNC_MAX_W; i++) begin
      c = c + {31'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_stages.sv
// Plain flop chain for bringing a Gray pointer into the local clock domain; no logic between stages.
module sync_stages #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // Shift the asynchronous input through the chain, clearing every stage on reset.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= {WIDTH{1'b0}};
      end
    end else begin
      r_stage[0] <= i_d;
      for (int k = 1; k < STAGES; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/sync_gray_ptr.sv
// Gray pointer synchroniser with registered binary view, update pulse and pointer advance.
// Build option SYNC_GRAY_CHECK_EN adds a sticky flag for illegal multi-bit Gray steps.
module sync_gray_ptr
  import sync_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter int STAGES   = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   rq_wptr,
  output logic [ADDRSIZE:0]   rq_wbin,
  output logic                rq_upd,
  output logic [ADDRSIZE:0]   rq_delta,
  output logic                rq_err
);

  localparam int W = ADDRSIZE + 1;

  if ((STAGES < SYNC_STAGES_MIN) || (STAGES > SYNC_STAGES_MAX)) begin : g_bad_stages
    $error("sync_gray_ptr: STAGES must lie in 2..4");
  end

  logic [W-1:0] w_sync;
  logic [W-1:0] w_bin;
  logic         w_upd;
  logic [W-1:0] w_delta;
  logic [W-1:0] r_wbin;
  logic         r_upd;
  logic [W-1:0] r_delta;

  sync_stages #(
    .WIDTH  (W),
    .STAGES (STAGES)
  ) u_stages (
    .rclk (rclk),
    .rrst (rrst),
    .i_d  (wptr),
    .o_q  (w_sync)
  );

  // Decode the synchronised pointer and measure how far it moved since the last registered value.
  always_comb begin
    w_bin   = W'(gray2bin(SYNC_MAX_W'(w_sync)));
    w_upd   = (w_bin != r_wbin);
    w_delta = {W{1'b0}};
    if (w_upd) begin
      w_delta = w_bin - r_wbin;
    end else begin
      w_delta = {W{1'b0}};
    end
  end

  // Register the binary pointer together with its update pulse and advance.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_wbin  <= {W{1'b0}};
      r_upd   <= 1'b0;
      r_delta <= {W{1'b0}};
    end else begin
      r_wbin  <= w_bin;
      r_upd   <= w_upd;
      r_delta <= w_delta;
    end
  end

  assign rq_wptr  = w_sync;
  assign rq_wbin  = r_wbin;
  assign rq_upd   = r_upd;
  assign rq_delta = r_delta;

`ifdef SYNC_GRAY_CHECK_EN
  logic r_armed;
  logic r_err;
  logic w_illegal;

  // A legal Gray step flips exactly one bit relative to the previously accepted pointer.
  always_comb begin
    w_illegal = (popcount(SYNC_MAX_W'(w_sync ^ W'(bin2gray(SYNC_MAX_W'(r_wbin))))) > 32'd1);
  end

  // The first update after reset only arms the checker; later updates are screened.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_armed <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_armed <= r_armed | w_upd;
      if (w_upd && r_armed && w_illegal) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

  assign rq_err = r_err;
`else
  assign rq_err = 1'b0;
`endif

endmodule
